// File: rtl/l_stf_stream_gen_if.sv
// Valid/ready sample stream from the L-STF generator to the TX sample mux.
interface l_stf_stream_gen_if #(
  parameter int unsigned IQ_WIDTH = 16
);
  logic [IQ_WIDTH-1:0] out_i;
  logic [IQ_WIDTH-1:0] out_q;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output out_i,
    output out_q,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_i,
    input  out_q,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/l_stf_stream_gen.sv
// L-STF preamble streamer: NUM_PERIODS repetitions of the 16-sample short training
// period with optional edge windowing, width reduction, attenuation and abort.
module l_stf_stream_gen #(
  parameter int unsigned IQ_WIDTH    = 16,
  parameter int unsigned NUM_PERIODS = 10,
  parameter int unsigned WINDOW_EN   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                gain_shift,
  output logic                      busy,
  output logic                      done,
  l_stf_stream_gen_if.master        stream
);

  localparam int unsigned LEN     = 16 * NUM_PERIODS + WINDOW_EN;
  localparam logic [7:0]  LAST_N  = 8'(LEN - 1);
  localparam logic [4:0]  BASE_SH = 5'(16 - IQ_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          n;
  logic [1:0]          gain_reg;
  logic [IQ_WIDTH-1:0] data_i, data_q;
  logic                load_en, adv_en;
  logic                xfer, at_last;
  logic [7:0]          nxt_idx;
  logic [31:0]         entry;
  logic                half;
  logic [4:0]          shamt;

  function automatic logic [31:0] stf_entry(input logic [3:0] a);
    logic [31:0] e;
    case (a)
      4'd0:    e = 32'hfd0e_fd0e;
      4'd1:    e = 32'hfc27_0198;
      4'd2:    e = 32'h0000_042a;
      4'd3:    e = 32'h03d9_0198;
      4'd4:    e = 32'h02f2_fd0e;
      4'd5:    e = 32'hfe68_fc27;
      4'd6:    e = 32'hfbd6_0000;
      4'd7:    e = 32'hfe68_03d9;
      4'd8:    e = 32'h02f2_02f2;
      4'd9:    e = 32'h03d9_fe68;
      4'd10:   e = 32'h0000_fbd6;
      4'd11:   e = 32'hfc27_fe68;
      4'd12:   e = 32'hfd0e_02f2;
      4'd13:   e = 32'h0198_03d9;
      4'd14:   e = 32'h042a_0000;
      default: e = 32'h0198_fc27;
    endcase
    return e;
  endfunction

  // Window halving is a second shift on the already-scaled value, so truncation
  // happens twice exactly as the reference arithmetic does.
  function automatic logic [IQ_WIDTH-1:0] scale(input logic [15:0] comp,
                                                input logic [4:0]  sh,
                                                input logic        hv);
    logic signed [15:0] t;
    t = $signed(comp) >>> sh;
    if (hv) t = t >>> 1;
    return t[IQ_WIDTH-1:0];
  endfunction

  assign xfer    = stream.out_valid & stream.out_ready;
  assign at_last = (n == LAST_N);
  assign nxt_idx = load_en ? '0 : n + 8'd1;
  assign entry   = stf_entry(nxt_idx[3:0]);
  assign half    = (WINDOW_EN != 0) && ((nxt_idx == '0) || (nxt_idx == LAST_N));
  assign shamt   = BASE_SH + {3'b000, gain_reg};

  assign stream.out_i = data_i;
  assign stream.out_q = data_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    load_en          = 1'b0;
    adv_en           = 1'b0;
    stream.out_valid = 1'b0;
    stream.out_last  = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        load_en   = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        busy             = 1'b1;
        stream.out_valid = 1'b1;
        stream.out_last  = at_last;
        if (abort)        state_nxt = IDLE;
        else if (xfer) begin
          if (at_last)    state_nxt = DONE;
          else            adv_en    = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The sample for the next index is prepared ahead so the output registers
  // update on the same edge that accepts the current one: no bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      n        <= '0;
      gain_reg <= '0;
      data_i   <= '0;
      data_q   <= '0;
    end else begin
      if (state == IDLE && start && !abort) gain_reg <= gain_shift;
      if (load_en) begin
        n      <= '0;
        data_i <= scale(entry[31:16], shamt, half);
        data_q <= scale(entry[15:0],  shamt, half);
      end else if (adv_en) begin
        n      <= n + 8'd1;
        data_i <= scale(entry[31:16], shamt, half);
        data_q <= scale(entry[15:0],  shamt, half);
      end
    end
  end

endmodule

// File: tb/tb_l_stf_stream_gen.sv
// Scoreboard bench for l_stf_stream_gen: three parameterisations share stimulus,
// expected samples come from a floor-division model of the preamble rules.
module tb_l_stf_stream_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       start0 = 0, start1 = 0, start2 = 0;
  logic       abort0 = 0, abort1 = 0, abort2 = 0;
  logic [1:0] gain0 = 0, gain1 = 0, gain2 = 0;
  logic       busy0, busy1, busy2, done0, done1, done2;
  bit         rmode0 = 0, rmode1 = 0, rmode2 = 0;

  l_stf_stream_gen_if #(.IQ_WIDTH(16)) s0();
  l_stf_stream_gen_if #(.IQ_WIDTH(16)) s1();
  l_stf_stream_gen_if #(.IQ_WIDTH(12)) s2();

  l_stf_stream_gen #(.IQ_WIDTH(16), .NUM_PERIODS(10), .WINDOW_EN(1)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort0), .gain_shift(gain0),
    .busy(busy0), .done(done0), .stream(s0));
  l_stf_stream_gen #(.IQ_WIDTH(16), .NUM_PERIODS(2), .WINDOW_EN(0)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1), .gain_shift(gain1),
    .busy(busy1), .done(done1), .stream(s1));
  l_stf_stream_gen #(.IQ_WIDTH(12), .NUM_PERIODS(1), .WINDOW_EN(1)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .abort(abort2), .gain_shift(gain2),
    .busy(busy2), .done(done2), .stream(s2));

  typedef struct { int i; int q; bit last; } samp_t;
  samp_t q0[$], q1[$], q2[$];
  int    cap0_i[$], cap0_q[$], cap1_i[$], cap1_q[$], cap2_i[$], cap2_q[$];
  int    vectors = 0, miscompares = 0;

  logic [15:0] tbl_hi [16] = '{16'hfd0e, 16'hfc27, 16'h0000, 16'h03d9, 16'h02f2, 16'hfe68,
                               16'hfbd6, 16'hfe68, 16'h02f2, 16'h03d9, 16'h0000, 16'hfc27,
                               16'hfd0e, 16'h0198, 16'h042a, 16'h0198};
  logic [15:0] tbl_lo [16] = '{16'hfd0e, 16'h0198, 16'h042a, 16'h0198, 16'hfd0e, 16'hfc27,
                               16'h0000, 16'h03d9, 16'h02f2, 16'hfe68, 16'hfbd6, 16'hfe68,
                               16'h02f2, 16'h03d9, 16'h0000, 16'hfc27};

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic samp_t model(int iqw, int np, int we, int gs, int n);
    samp_t s;
    int    len = 16 * np + we;
    real   d   = 2.0 ** (16 - iqw + gs);
    int    hi  = int'($signed(tbl_hi[n % 16]));
    int    lo  = int'($signed(tbl_lo[n % 16]));
    int    vi  = int'($floor(hi / d));
    int    vq  = int'($floor(lo / d));
    if (we == 1 && (n == 0 || n == len - 1)) begin
      vi = int'($floor(vi / 2.0));
      vq = int'($floor(vq / 2.0));
    end
    s.i    = vi & ((1 << iqw) - 1);
    s.q    = vq & ((1 << iqw) - 1);
    s.last = (n == len - 1);
    return s;
  endfunction

  task automatic start_burst(input int inst, input int gs);
    case (inst)
      0: begin gain0 = 2'(gs); start0 = 1;
           for (int n = 0; n < 161; n++) q0.push_back(model(16, 10, 1, gs, n)); end
      1: begin gain1 = 2'(gs); start1 = 1;
           for (int n = 0; n < 32; n++)  q1.push_back(model(16, 2, 0, gs, n)); end
      default: begin gain2 = 2'(gs); start2 = 1;
           for (int n = 0; n < 17; n++)  q2.push_back(model(12, 1, 1, gs, n)); end
    endcase
    @(posedge clock); #1;
    start0 = 0; start1 = 0; start2 = 0;
  endtask

  task automatic drain(input int inst, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (inst == 0 && q0.size() == 0 && !busy0) break;
      if (inst == 1 && q1.size() == 0 && !busy1) break;
      if (inst == 2 && q2.size() == 0 && !busy2) break;
      @(posedge clock); #1;
    end
    if (k == budget) chk($sformatf("timeout_inst%0d", inst), 0, 1);
    repeat (2) begin @(posedge clock); #1; end
  endtask

  always @(posedge clock) begin
    #1;
    s0.out_ready = rmode0 ? 1'($urandom % 2) : 1'b1;
    s1.out_ready = rmode1 ? 1'($urandom % 2) : 1'b1;
    s2.out_ready = rmode2 ? 1'($urandom % 2) : 1'b1;
  end

  // Monitors: pop on every transfer, check stall stability and the done pulse.
  samp_t e0, e1, e2;
  bit    pend0, pend1, pend2, stv0, stv1, stv2;
  int    sti0, stq0, stl0, sti1, stq1, stl1, sti2, stq2, stl2;

  always @(negedge clock) begin
    if (reset) begin pend0 = 0; stv0 = 0; end
    else begin
      if (pend0 || done0) chk("done0", int'(done0), int'(pend0));
      pend0 = 0;
      if (stv0) begin
        chk("stall_i0", s0.out_i, sti0); chk("stall_q0", s0.out_q, stq0);
        chk("stall_last0", s0.out_last, stl0);
      end
      if (s0.out_valid && s0.out_ready) begin
        if (q0.size() == 0) chk("unexpected_xfer0", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("i0", s0.out_i, e0.i); chk("q0", s0.out_q, e0.q);
          chk("last0", s0.out_last, int'(e0.last));
          cap0_i.push_back(s0.out_i); cap0_q.push_back(s0.out_q);
          pend0 = e0.last;
        end
      end
      stv0 = s0.out_valid && !s0.out_ready;
      sti0 = s0.out_i; stq0 = s0.out_q; stl0 = s0.out_last;
    end
  end

  always @(negedge clock) begin
    if (reset) begin pend1 = 0; stv1 = 0; end
    else begin
      if (pend1 || done1) chk("done1", int'(done1), int'(pend1));
      pend1 = 0;
      if (stv1) begin
        chk("stall_i1", s1.out_i, sti1); chk("stall_q1", s1.out_q, stq1);
        chk("stall_last1", s1.out_last, stl1);
      end
      if (s1.out_valid && s1.out_ready) begin
        if (q1.size() == 0) chk("unexpected_xfer1", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("i1", s1.out_i, e1.i); chk("q1", s1.out_q, e1.q);
          chk("last1", s1.out_last, int'(e1.last));
          cap1_i.push_back(s1.out_i); cap1_q.push_back(s1.out_q);
          pend1 = e1.last;
        end
      end
      stv1 = s1.out_valid && !s1.out_ready;
      sti1 = s1.out_i; stq1 = s1.out_q; stl1 = s1.out_last;
    end
  end

  always @(negedge clock) begin
    if (reset) begin pend2 = 0; stv2 = 0; end
    else begin
      if (pend2 || done2) chk("done2", int'(done2), int'(pend2));
      pend2 = 0;
      if (stv2) begin
        chk("stall_i2", s2.out_i, sti2); chk("stall_q2", s2.out_q, stq2);
        chk("stall_last2", s2.out_last, stl2);
      end
      if (s2.out_valid && s2.out_ready) begin
        if (q2.size() == 0) chk("unexpected_xfer2", 1, 0);
        else begin
          e2 = q2.pop_front();
          chk("i2", s2.out_i, e2.i); chk("q2", s2.out_q, e2.q);
          chk("last2", s2.out_last, int'(e2.last));
          cap2_i.push_back(s2.out_i); cap2_q.push_back(s2.out_q);
          pend2 = e2.last;
        end
      end
      stv2 = s2.out_valid && !s2.out_ready;
      sti2 = s2.out_i; stq2 = s2.out_q; stl2 = s2.out_last;
    end
  end

  initial begin
    int b, k;
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    chk("rst_valid", s0.out_valid, 0); chk("rst_last", s0.out_last, 0);
    chk("rst_i", s0.out_i, 0);         chk("rst_busy", busy0, 0);

    // Default burst, ready high: latency, anchor samples, length.
    rmode0 = 0; b = cap0_i.size();
    start_burst(0, 0);
    chk("lat_load_valid", s0.out_valid, 0); chk("lat_load_busy", busy0, 1);
    @(posedge clock); #1;
    chk("lat_run_valid", s0.out_valid, 1);
    drain(0, 400);
    chk("len_default", cap0_i.size() - b, 161);
    chk("n0_i", cap0_i[b], 16'hfe87);       chk("n0_q", cap0_q[b], 16'hfe87);
    chk("n1_i", cap0_i[b + 1], 16'hfc27);   chk("n1_q", cap0_q[b + 1], 16'h0198);
    chk("n160_i", cap0_i[b + 160], 16'hfe87); chk("n160_q", cap0_q[b + 160], 16'hfe87);

    // Random backpressure, then a random-gain burst.
    rmode0 = 1; b = cap0_i.size();
    start_burst(0, 0); drain(0, 2000);
    chk("len_stalled", cap0_i.size() - b, 161);
    start_burst(0, int'($urandom_range(3))); drain(0, 2000);

    // No windowing, two periods.
    rmode1 = 1; b = cap1_i.size();
    start_burst(1, 0); drain(1, 500);
    chk("len_nowin", cap1_i.size() - b, 32);
    chk("nowin_n0_i", cap1_i[b], 16'hfd0e);      chk("nowin_n0_q", cap1_q[b], 16'hfd0e);
    chk("nowin_n16_i", cap1_i[b + 16], 16'hfd0e); chk("nowin_n16_q", cap1_q[b + 16], 16'hfd0e);

    // 12-bit output with gain_shift 2, then random gains.
    rmode2 = 1; b = cap2_i.size();
    start_burst(2, 2); drain(2, 500);
    chk("w12_n2_i", cap2_i[b + 2], 12'h000); chk("w12_n2_q", cap2_q[b + 2], 12'h010);
    chk("w12_n6_i", cap2_i[b + 6], 12'hfef); chk("w12_n6_q", cap2_q[b + 6], 12'h000);
    chk("w12_n1_i", cap2_i[b + 1], 12'hff0); chk("w12_n1_q", cap2_q[b + 1], 12'h006);
    for (int r = 0; r < 3; r++) begin
      start_burst(2, int'($urandom_range(3))); drain(2, 500);
    end

    // Abort at n=50, then restart.
    rmode0 = 0; b = cap0_i.size();
    start_burst(0, 0);
    for (k = 0; k < 200 && cap0_i.size() - b < 50; k++) begin @(posedge clock); #1; end
    if (k == 200) chk("timeout_abort_wait", 0, 1);
    abort0 = 1;
    @(posedge clock); #1;
    abort0 = 0;
    chk("abort_valid", s0.out_valid, 0); chk("abort_busy", busy0, 0);
    chk("abort_xfers", cap0_i.size() - b, 51);
    q0.delete();
    repeat (3) begin @(posedge clock); #1; end
    rmode0 = 1; b = cap0_i.size();
    start_burst(0, 0); drain(0, 2000);
    chk("restart_n0_i", cap0_i[b], 16'hfe87);
    chk("restart_len", cap0_i.size() - b, 161);

    // start together with abort while idle.
    start1 = 1; abort1 = 1;
    @(posedge clock); #1;
    start1 = 0; abort1 = 0;
    chk("start_abort_busy", busy1, 0);
    @(posedge clock); #1;
    chk("start_abort_valid", s1.out_valid, 0);

    // Start ignored mid-burst, then reset at n=80.
    rmode0 = 1; b = cap0_i.size();
    start_burst(0, 0);
    for (k = 0; k < 500 && cap0_i.size() - b < 30; k++) begin @(posedge clock); #1; end
    gain0 = 3; start0 = 1;
    @(posedge clock); #1;
    start0 = 0; gain0 = 0;
    for (k = 0; k < 1000 && cap0_i.size() - b < 80; k++) begin @(posedge clock); #1; end
    if (k == 1000) chk("timeout_reset_wait", 0, 1);
    reset = 1;
    @(posedge clock); #1;
    chk("midrst_i", s0.out_i, 0);       chk("midrst_q", s0.out_q, 0);
    chk("midrst_valid", s0.out_valid, 0); chk("midrst_last", s0.out_last, 0);
    chk("midrst_busy", busy0, 0);       chk("midrst_done", done0, 0);
    reset = 0;
    q0.delete();
    @(posedge clock); #1;
    rmode0 = 0; b = cap0_i.size();
    start_burst(0, 0); drain(0, 400);
    chk("post_rst_len", cap0_i.size() - b, 161);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
